// File: rtl/psc_trigger_pkg.sv
// Shared constants and types for the PSC sync-frame trigger.
// Frame bytes: sync address, sync-pulse command, 16-bit size 0x0001, checksum.
package psc_trigger_pkg;

    localparam int unsigned FRAME_LEN_DEFAULT = 5;
    localparam int unsigned FRAME_IDX_W       = $clog2(FRAME_LEN_DEFAULT);

    // Two's-complement checksum: all five bytes sum to 0 mod 256.
    localparam logic [7:0] PSC_SYNC_FRAME [FRAME_LEN_DEFAULT] =
        '{8'hFF, 8'h50, 8'h00, 8'h01, 8'hB0};

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } psc_state_t;

    function automatic logic [7:0] frame_byte(input int unsigned idx);
        logic [7:0] b;
        if (idx < FRAME_LEN_DEFAULT) begin
            b = PSC_SYNC_FRAME[idx[FRAME_IDX_W-1:0]];
        end else begin
            b = 8'h00;
        end
        return b;
    endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 LSB-first byte serialiser with a registered line output.
// A start request during the last stop-bit cycle chains the next byte with no idle gap.
module uart_tx_byte
    import psc_trigger_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] data,
    output logic       busy,
    output logic       done,
    output logic       txd
);

    localparam int unsigned CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(CLKS_PER_BIT - 1);

    psc_state_t    state;
    logic [CW-1:0] cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shreg;
    logic          bit_end;

    assign bit_end = (cnt == CNT_MAX);
    assign busy    = (state != IDLE);
    assign done    = (state == STOP) && bit_end;

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            shreg   <= '0;
            txd     <= 1'b1;
        end else begin
            cnt <= ((state == IDLE) || bit_end) ? '0 : cnt + 1'b1;
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= START;
                        shreg <= data;
                        txd   <= 1'b0;
                    end
                end
                START: begin
                    if (bit_end) begin
                        state   <= DATA;
                        bit_idx <= '0;
                        txd     <= shreg[0];
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        if (bit_idx == 3'd7) begin
                            state <= STOP;
                            txd   <= 1'b1;
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                            txd     <= shreg[1];
                            shreg   <= {1'b0, shreg[7:1]};
                        end
                    end
                end
                STOP: begin
                    if (bit_end) begin
                        if (start) begin
                            state <= START;
                            shreg <= data;
                            txd   <= 1'b0;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    txd   <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: rtl/psc_trigger.sv
// EVR trigger -> PSC sync frame: input synchroniser, rising-edge detect and byte sequencer
// driving a single uart_tx_byte. Edges arriving while a frame is in flight are dropped.
module psc_trigger
    import psc_trigger_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter int unsigned FRAME_LEN    = FRAME_LEN_DEFAULT
) (
    input  logic clk,
    input  logic reset,
    input  logic evr_trigger,
    output logic psc_output
);

    localparam int unsigned BW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;

    logic          s1, s2, s3;
    logic          rise_q;
    logic          active;
    logic [BW-1:0] byte_idx;
    logic [BW-1:0] nxt_idx;
    logic          launch, last, next_byte, start;
    logic [7:0]    tx_data;
    logic          busy, done;

    // rise_q adds one stage so the start bit appears three edges after first sampling.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1       <= 1'b0;
            s2       <= 1'b0;
            s3       <= 1'b0;
            rise_q   <= 1'b0;
            active   <= 1'b0;
            byte_idx <= '0;
        end else begin
            s1     <= evr_trigger;
            s2     <= s1;
            s3     <= s2;
            rise_q <= s2 & ~s3;
            if (launch) begin
                active   <= 1'b1;
                byte_idx <= '0;
            end else if (done) begin
                if (last) begin
                    active   <= 1'b0;
                    byte_idx <= '0;
                end else begin
                    byte_idx <= nxt_idx;
                end
            end
        end
    end

    // Next byte is requested combinationally alongside done so bytes abut exactly.
    always_comb begin
        nxt_idx   = byte_idx + 1'b1;
        launch    = ~active & ~busy & rise_q;
        last      = (byte_idx == BW'(FRAME_LEN - 1));
        next_byte = done & ~last;
        start     = launch | next_byte;
        tx_data   = next_byte ? frame_byte(32'(nxt_idx)) : frame_byte(0);
    end

    uart_tx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_tx (
        .clk  (clk),
        .reset(reset),
        .start(start),
        .data (tx_data),
        .busy (busy),
        .done (done),
        .txd  (psc_output)
    );

endmodule

// File: tb/tb_psc_trigger.sv
// Directed bench for psc_trigger: latency, frame content/timing, drop rules, reset abort, fast baud.
module tb_psc_trigger;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    logic trig1 = 1'b0;
    logic trig2 = 1'b0;
    logic out1, out2;

    int tests = 0;
    int fails = 0;

    logic [7:0] exp_frame [5] = '{8'hFF, 8'h50, 8'h00, 8'h01, 8'hB0};
    logic [7:0] got [5];
    int         bad_cycles;

    always #5 clk = ~clk;

    psc_trigger #(.CLKS_PER_BIT(16)) dut (
        .clk(clk), .reset(reset), .evr_trigger(trig1), .psc_output(out1)
    );

    psc_trigger #(.CLKS_PER_BIT(2)) dut_fast (
        .clk(clk), .reset(reset), .evr_trigger(trig2), .psc_output(out2)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic line(input int sel);
        return (sel != 0) ? out2 : out1;
    endfunction

    task automatic drive(input int sel, input logic v);
        if (sel != 0) trig2 = v;
        else          trig1 = v;
    endtask

    task automatic pulse(input int sel);
        drive(sel, 1'b1);
        tick();
        drive(sel, 1'b0);
    endtask

    // Edges counted after the first sampling edge until the line drops; -1 on timeout.
    task automatic wait_start(input int sel, output int lat);
        lat = -1;
        for (int i = 1; i <= 50; i++) begin
            tick();
            if (line(sel) === 1'b0) begin
                lat = i;
                break;
            end
        end
    endtask

    // Samples a whole frame starting at cycle 0 of the first start bit.
    task automatic capture(input int sel, input int cpb, input int pulse_at);
        int pos, byt, total;
        logic e;
        logic [7:0] eb;
        total = 50 * cpb;
        bad_cycles = 0;
        for (int b = 0; b < 5; b++) got[b] = '0;
        for (int i = 0; i < total; i++) begin
            pos = (i / cpb) % 10;
            byt = i / (10 * cpb);
            eb  = exp_frame[byt];
            if (pos == 0)      e = 1'b0;
            else if (pos == 9) e = 1'b1;
            else               e = eb[pos-1];
            if (line(sel) !== e) bad_cycles++;
            if (pos >= 1 && pos <= 8 && (i % cpb) == cpb / 2) got[byt][pos-1] = line(sel);
            if (i == pulse_at)          drive(sel, 1'b1);
            else if (i == pulse_at + 1) drive(sel, 1'b0);
            tick();
        end
    endtask

    task automatic count_low(input int sel, input int n, output int lows);
        lows = 0;
        for (int i = 0; i < n; i++) begin
            if (line(sel) !== 1'b1) lows++;
            tick();
        end
    endtask

    task automatic test_reset();
        int lows;
        reset = 1'b1;
        repeat (3) tick();
        tests++;
        if (out1 !== 1'b1) begin fails++; $display("FAIL reset_out: got %b, expected 1", out1); end
        tests++;
        if (out2 !== 1'b1) begin fails++; $display("FAIL reset_out_fast: got %b, expected 1", out2); end
        reset = 1'b0;
        count_low(0, 100, lows);
        tests++;
        if (lows !== 0) begin fails++; $display("FAIL idle_quiet: got %0d low cycles, expected 0", lows); end
    endtask

    task automatic test_single_frame();
        int lat, lows;
        pulse(0);
        wait_start(0, lat);
        tests++;
        if (lat !== 3) begin fails++; $display("FAIL latency: got %0d, expected 3", lat); end
        capture(0, 16, -1);
        for (int b = 0; b < 5; b++) begin
            tests++;
            if (got[b] !== exp_frame[b]) begin
                fails++;
                $display("FAIL byte%0d: got %h, expected %h", b, got[b], exp_frame[b]);
            end
        end
        tests++;
        if (bad_cycles !== 0) begin fails++; $display("FAIL frame_timing: got %0d bad cycles, expected 0", bad_cycles); end
        count_low(0, 100, lows);
        tests++;
        if (lows !== 0) begin fails++; $display("FAIL idle_after_frame: got %0d low cycles, expected 0", lows); end
    endtask

    task automatic test_ignore_during_frame();
        int lat, lows;
        pulse(0);
        wait_start(0, lat);
        capture(0, 16, 200);
        tests++;
        if (bad_cycles !== 0) begin fails++; $display("FAIL mid_pulse_frame: got %0d bad cycles, expected 0", bad_cycles); end
        count_low(0, 200, lows);
        tests++;
        if (lows !== 0) begin fails++; $display("FAIL mid_pulse_dropped: got %0d low cycles, expected 0", lows); end
        pulse(0);
        wait_start(0, lat);
        tests++;
        if (lat !== 3) begin fails++; $display("FAIL rearm_latency: got %0d, expected 3", lat); end
        capture(0, 16, -1);
        tests++;
        if (bad_cycles !== 0) begin fails++; $display("FAIL rearm_frame: got %0d bad cycles, expected 0", bad_cycles); end
    endtask

    task automatic test_back_to_back();
        int lat, lows;
        // Edge lands on the final stop-bit cycle: still busy, must be dropped.
        pulse(0);
        wait_start(0, lat);
        capture(0, 16, 796);
        count_low(0, 100, lows);
        tests++;
        if (lows !== 0) begin fails++; $display("FAIL late_edge_dropped: got %0d low cycles, expected 0", lows); end
        // Edge lands on the cycle the sequencer is back in idle: accepted.
        pulse(0);
        wait_start(0, lat);
        capture(0, 16, 797);
        tests++;
        if (bad_cycles !== 0) begin fails++; $display("FAIL b2b_first_frame: got %0d bad cycles, expected 0", bad_cycles); end
        tests++;
        if (out1 !== 1'b1) begin fails++; $display("FAIL b2b_gap: got %b, expected 1", out1); end
        tick();
        tests++;
        if (out1 !== 1'b0) begin fails++; $display("FAIL b2b_restart: got %b, expected 0", out1); end
        capture(0, 16, -1);
        tests++;
        if (bad_cycles !== 0) begin fails++; $display("FAIL b2b_second_frame: got %0d bad cycles, expected 0", bad_cycles); end
    endtask

    task automatic test_level_high();
        int lat, lows;
        drive(0, 1'b1);
        tick();
        wait_start(0, lat);
        tests++;
        if (lat !== 3) begin fails++; $display("FAIL level_latency: got %0d, expected 3", lat); end
        capture(0, 16, -1);
        tests++;
        if (bad_cycles !== 0) begin fails++; $display("FAIL level_frame: got %0d bad cycles, expected 0", bad_cycles); end
        count_low(0, 1190, lows);
        tests++;
        if (lows !== 0) begin fails++; $display("FAIL level_single: got %0d low cycles, expected 0", lows); end
        drive(0, 1'b0);
        count_low(0, 10, lows);
        tests++;
        if (lows !== 0) begin fails++; $display("FAIL level_release: got %0d low cycles, expected 0", lows); end
        pulse(0);
        wait_start(0, lat);
        tests++;
        if (lat !== 3) begin fails++; $display("FAIL level_rearm_latency: got %0d, expected 3", lat); end
        capture(0, 16, -1);
        tests++;
        if (bad_cycles !== 0) begin fails++; $display("FAIL level_rearm_frame: got %0d bad cycles, expected 0", bad_cycles); end
    endtask

    task automatic test_reset_mid_frame();
        int lat, lows;
        pulse(0);
        wait_start(0, lat);
        repeat (350) tick();
        tests++;
        if (out1 !== 1'b0) begin fails++; $display("FAIL pre_reset_low: got %b, expected 0", out1); end
        reset = 1'b1;
        tick();
        tests++;
        if (out1 !== 1'b1) begin fails++; $display("FAIL reset_abort: got %b, expected 1", out1); end
        reset = 1'b0;
        count_low(0, 900, lows);
        tests++;
        if (lows !== 0) begin fails++; $display("FAIL no_resume: got %0d low cycles, expected 0", lows); end
        pulse(0);
        wait_start(0, lat);
        tests++;
        if (lat !== 3) begin fails++; $display("FAIL post_reset_latency: got %0d, expected 3", lat); end
        capture(0, 16, -1);
        tests++;
        if (bad_cycles !== 0) begin fails++; $display("FAIL post_reset_frame: got %0d bad cycles, expected 0", bad_cycles); end
    endtask

    task automatic test_fast_baud();
        int lat, lows;
        pulse(1);
        wait_start(1, lat);
        tests++;
        if (lat !== 3) begin fails++; $display("FAIL fast_latency: got %0d, expected 3", lat); end
        capture(1, 2, -1);
        for (int b = 0; b < 5; b++) begin
            tests++;
            if (got[b] !== exp_frame[b]) begin
                fails++;
                $display("FAIL fast_byte%0d: got %h, expected %h", b, got[b], exp_frame[b]);
            end
        end
        tests++;
        if (bad_cycles !== 0) begin fails++; $display("FAIL fast_timing: got %0d bad cycles, expected 0", bad_cycles); end
        count_low(1, 20, lows);
        tests++;
        if (lows !== 0) begin fails++; $display("FAIL fast_idle_after: got %0d low cycles, expected 0", lows); end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_ignore_during_frame();
        test_back_to_back();
        test_level_high();
        test_reset_mid_frame();
        test_fast_baud();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
